// File: rtl/mmio_periph.sv
// rtl/mmio_periph.sv - memory-mapped LED/HEX/KEY/SW/timer peripheral for the RISC-V data bus
module mmio_periph #(
  parameter int IO_BIT          = 8,
  parameter int LED_W           = 10,
  parameter int NUM_HEX         = 6,
  parameter int KEY_W           = 4,
  parameter int SW_W            = 10,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            addr,
  input  logic [31:0]            writedata,
  input  logic [3:0]             writemask,
  input  logic                   memwrite,
  output logic [31:0]            readdata,
  output logic                   isIO,
  output logic [LED_W-1:0]       LEDR,
  output logic [4*NUM_HEX-1:0]   hex_digits,
  input  logic [KEY_W-1:0]       KEY,
  input  logic [SW_W-1:0]        SW
);

  localparam int HEX_W = 4 * NUM_HEX;
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [5:0]       sel_raw, sel;
  logic             wr;
  logic [31:0]      bmask, wd_masked;
  logic [31:0]      led_ext, hex_ext, key_ext, sw_ext, evt_ext;
  logic [31:0]      led_new, hex_new;
  logic [31:0]      timer;
  logic [KEY_W-1:0] key_s1, key_s2, key_deb, key_deb_nx;
  logic [KEY_W-1:0] key_evt, key_evt_nx, evt_set, evt_clr;
  logic [SW_W-1:0]  sw_s1, sw_s2;
  logic [CNT_W-1:0] key_cnt    [KEY_W];
  logic [CNT_W-1:0] key_cnt_nx [KEY_W];
  logic             unused_bits;

  assign isIO    = addr[IO_BIT];
  assign sel_raw = addr[7:2];
  // Isolate the lowest set select bit so overlapping selects resolve deterministically.
  assign sel     = sel_raw & (~sel_raw + 6'd1);
  assign wr      = memwrite & isIO & (|sel_raw);

  assign bmask     = {{8{writemask[3]}}, {8{writemask[2]}}, {8{writemask[1]}}, {8{writemask[0]}}};
  assign wd_masked = writedata & bmask;

  always_comb begin
    led_ext = '0;
    hex_ext = '0;
    key_ext = '0;
    sw_ext  = '0;
    evt_ext = '0;
    led_ext[LED_W-1:0] = LEDR;
    hex_ext[HEX_W-1:0] = hex_digits;
    key_ext[KEY_W-1:0] = key_deb;
    sw_ext[SW_W-1:0]   = sw_s2;
    evt_ext[KEY_W-1:0] = key_evt;
  end

  assign led_new = (led_ext & ~bmask) | wd_masked;
  assign hex_new = (hex_ext & ~bmask) | wd_masked;

  always_comb begin
    key_deb_nx = key_deb;
    for (int i = 0; i < KEY_W; i++) begin
      key_cnt_nx[i] = '0;
      if (key_s2[i] != key_deb[i]) begin
        if (key_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1))
          key_deb_nx[i] = key_s2[i];
        else
          key_cnt_nx[i] = key_cnt[i] + 1'b1;
      end
    end
  end

  // Set beats clear so a press landing on a W1C write is never lost.
  assign evt_set    = key_deb & ~key_deb_nx;
  assign evt_clr    = (wr && sel[4]) ? wd_masked[KEY_W-1:0] : '0;
  assign key_evt_nx = (key_evt & ~evt_clr) | evt_set;

  always_comb begin
    readdata = '0;
    if (isIO) begin
      if (sel[0])      readdata = led_ext;
      else if (sel[1]) readdata = hex_ext;
      else if (sel[2]) readdata = key_ext;
      else if (sel[3]) readdata = sw_ext;
      else if (sel[4]) readdata = evt_ext;
      else if (sel[5]) readdata = timer;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      LEDR       <= '0;
      hex_digits <= '0;
      key_s1     <= '1;
      key_s2     <= '1;
      key_deb    <= '1;
      key_evt    <= '0;
      sw_s1      <= '0;
      sw_s2      <= '0;
      timer      <= '0;
      for (int i = 0; i < KEY_W; i++) key_cnt[i] <= '0;
    end else begin
      if (wr && sel[0]) LEDR       <= led_new[LED_W-1:0];
      if (wr && sel[1]) hex_digits <= hex_new[HEX_W-1:0];
      key_s1  <= KEY;
      key_s2  <= key_s1;
      key_deb <= key_deb_nx;
      key_evt <= key_evt_nx;
      sw_s1   <= SW;
      sw_s2   <= sw_s1;
      timer   <= (wr && sel[5]) ? 32'd0 : timer + 32'd1;
      for (int i = 0; i < KEY_W; i++) key_cnt[i] <= key_cnt_nx[i];
    end
  end

  assign unused_bits = ^{addr, led_new, hex_new};

endmodule
